shiftadd_mac_param: RTL and testbench

Parametrised sequential multiply-accumulate unit, the next generation of the team's 8-bit shift-add multiplier. It takes two N-bit operands on a start strobe and produces the 2N-bit product after N iteration cycles. Each operation chooses unsigned shift-add or signed radix-2 Booth. An optional accumulate step adds the product into a wider guarded accumulator with sticky overflow. It sits beside the datapath as a multi-cycle arithmetic resource and is driven by a controller through a start/stop handshake.

---
 rtl/shiftadd_pkg.sv | 21 ++
 rtl/shiftadd_mac_param_booth_step.sv | 44 ++++
 rtl/shiftadd_mac_param.sv | 158 +++++++++++++++
 tb/tb_shiftadd_mac_param.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shiftadd_pkg.sv
// Shared types and constants for the parametrised shift-add / Booth MAC.
package shiftadd_pkg;

    // Default operand width and number of accumulator guard bits above 2N.
    localparam int DEF_N     = 8;
    localparam int ACC_GUARD = 4;

    // Controller states; the encoding is also exported on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Booth pair {q[0], q_-1} encodings.
    localparam logic [1:0] BOOTH_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage

// File: rtl/shiftadd_mac_param_booth_step.sv
// One combinational multiply iteration: conditional add/subtract of the
// multiplicand into the N+1-bit upper register, then a one-bit right shift
// of {upper, q}. Unsigned mode shifts in a zero, signed (Booth) mode shifts
// in the sign so the upper register stays a valid two's-complement value.
module booth_step
    import shiftadd_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         signed_mode,
    input  logic [N:0]   a_in,
    input  logic [N-1:0] q_in,
    input  logic         qm1_in,
    input  logic [N-1:0] b_in,
    output logic [N:0]   a_out,
    output logic [N-1:0] q_out,
    output logic         qm1_out
);

    logic [N:0] b_ext;
    logic [N:0] sum;
    logic [1:0] pair;

    // Add/subtract decision followed by the shift of {upper, q}.
    always_comb begin
        b_ext = signed_mode ? {b_in[N-1], b_in} : {1'b0, b_in};
        pair  = {q_in[0], qm1_in};
        sum   = a_in;
        if (signed_mode) begin
            case (pair)
                BOOTH_ADD: sum = a_in + b_ext;
                BOOTH_SUB: sum = a_in - b_ext;
                default:   sum = a_in;
            endcase
        end else if (q_in[0]) begin
            // Upper register is < 2^N here, so N+1 bits hold the carry.
            sum = a_in + b_ext;
        end
        a_out   = {(signed_mode & sum[N]), sum[N:1]};
        q_out   = {sum[0], q_in[N-1:1]};
        qm1_out = q_in[0];
    end

endmodule

// File: rtl/shiftadd_mac_param.sv
// Sequential N-bit multiplier (unsigned shift-add or signed Booth) with an
// optional accumulate into a guarded ACC_W-bit accumulator and a sticky
// overflow flag. Handshake: start is sampled only when busy=0 (IDLE or DONE);
// busy is high for the N iteration cycles; stop pulses for one cycle after
// the result edge, and a start seen in that DONE cycle chains the next op.
// N must be >= 2 and ACC_W >= 2*N.
module shiftadd_mac_param
    import shiftadd_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int ACC_W = 2*N + ACC_GUARD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic             acc_en,
    input  logic             acc_clr,
    input  logic [N-1:0]     b_in,
    input  logic [N-1:0]     q_in,
    output logic             busy,
    output logic             stop,
    output logic [2*N-1:0]   a_out,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(N + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       b_q, b_d;
    logic [N:0]         a_q, a_d;
    logic [N-1:0]       q_q, q_d;
    logic               qm1_q, qm1_d;
    logic               sgn_q, sgn_d;
    logic               acc_en_q, acc_en_d;
    logic [2*N-1:0]     a_out_q, a_out_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;

    logic [N:0]         step_a;
    logic [N-1:0]       step_q;
    logic               step_qm1;
    logic [2*N-1:0]     prod;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   acc_base;
    logic               ovf_base;
    logic [ACC_W:0]     acc_sum;
    logic               add_ovf;

    booth_step #(.N(N)) u_step (
        .signed_mode (sgn_q),
        .a_in        (a_q),
        .q_in        (q_q),
        .qm1_in      (qm1_q),
        .b_in        (b_q),
        .a_out       (step_a),
        .q_out       (step_q),
        .qm1_out     (step_qm1)
    );

    // Next-state logic: start acceptance, iteration, result and accumulate.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        b_d      = b_q;
        a_d      = a_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        sgn_d    = sgn_q;
        acc_en_d = acc_en_q;
        a_out_d  = a_out_q;

        // acc_clr is applied first so a coinciding accumulate adds into zero.
        acc_base = acc_clr ? '0 : acc_q;
        ovf_base = acc_clr ? 1'b0 : ovf_q;
        acc_d    = acc_base;
        ovf_d    = ovf_base;

        prod     = {step_a[N-1:0], step_q};
        prod_ext = sgn_q ? ACC_W'($signed(prod)) : ACC_W'(prod);
        acc_sum  = {1'b0, acc_base} + {1'b0, prod_ext};
        add_ovf  = sgn_q ? ((acc_base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                            (acc_sum[ACC_W-1] != acc_base[ACC_W-1]))
                         : acc_sum[ACC_W];

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    b_d      = b_in;
                    q_d      = q_in;
                    sgn_d    = signed_mode;
                    acc_en_d = acc_en;
                    a_d      = '0;
                    qm1_d    = 1'b0;
                    cnt_d    = CNT_W'(N);
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d   = step_a;
                q_d   = step_q;
                qm1_d = step_qm1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    a_out_d = prod;
                    if (acc_en_q) begin
                        acc_d = acc_sum[ACC_W-1:0];
                        ovf_d = ovf_base | add_ovf;
                    end
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            b_q      <= '0;
            a_q      <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            sgn_q    <= 1'b0;
            acc_en_q <= 1'b0;
            a_out_q  <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            b_q      <= b_d;
            a_q      <= a_d;
            q_q      <= q_d;
            qm1_q    <= qm1_d;
            sgn_q    <= sgn_d;
            acc_en_q <= acc_en_d;
            a_out_q  <= a_out_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign stop      = (state_q == ST_DONE);
    assign a_out     = a_out_q;
    assign acc_out   = acc_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_shiftadd_mac_param.sv
// Directed bench for shiftadd_mac_param: a default-width instance and an
// ACC_W=16 instance share all inputs so overflow can be exercised.
module tb_shiftadd_mac_param;

    logic        clk;
    logic        reset;
    logic        start;
    logic        signed_mode;
    logic        acc_en;
    logic        acc_clr;
    logic [7:0]  b_in;
    logic [7:0]  q_in;

    logic        busy, stop, ovf;
    logic [15:0] a_out;
    logic [19:0] acc_out;
    logic [1:0]  dbg_state;

    logic        busy16, stop16, ovf16;
    logic [15:0] a_out16;
    logic [15:0] acc_out16;
    logic [1:0]  dbg_state16;

    int checks;
    int errors;

    shiftadd_mac_param u_dut (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
        .acc_en(acc_en), .acc_clr(acc_clr), .b_in(b_in), .q_in(q_in),
        .busy(busy), .stop(stop), .a_out(a_out), .acc_out(acc_out),
        .ovf(ovf), .dbg_state(dbg_state)
    );

    shiftadd_mac_param #(.N(8), .ACC_W(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
        .acc_en(acc_en), .acc_clr(acc_clr), .b_in(b_in), .q_in(q_in),
        .busy(busy16), .stop(stop16), .a_out(a_out16), .acc_out(acc_out16),
        .ovf(ovf16), .dbg_state(dbg_state16)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    // Driver: one start pulse, then wait (bounded) for stop.
    // lat counts negedges after the start edge up to the one where stop is seen.
    task automatic run_op(input logic [7:0] b, input logic [7:0] q,
                          input logic sm, input logic ae,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        b_in = b; q_in = q; signed_mode = sm; acc_en = ae; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cnt = busy ? 1 : 0;
        while (!stop && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; signed_mode = 1'b0; acc_en = 1'b0;
        acc_clr = 1'b0; b_in = 8'h00; q_in = 8'h00;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, stop, ovf, a_out, acc_out, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b stop=%b ovf=%b a=%h acc=%h st=%0d want all 0",
                     busy, stop, ovf, a_out, acc_out, dbg_state);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (dbg_state !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle got st=%0d busy=%b want 0 0", dbg_state, busy);
        end
    endtask

    task automatic test_unsigned();
        int lat, bc;
        run_op(8'h0F, 8'h0E, 1'b0, 1'b0, lat, bc);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL unsigned_latency got %0d want 9", lat);
        end
        checks++;
        if (a_out !== 16'h00D2) begin
            errors++;
            $display("FAIL unsigned_a_out got %h want 00d2", a_out);
        end
        checks++;
        if (bc !== 8) begin
            errors++;
            $display("FAIL unsigned_busy_cycles got %0d want 8", bc);
        end
        checks++;
        if (dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL done_state got %0d want 2", dbg_state);
        end
        @(negedge clk);
        checks++;
        if (stop !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL stop_one_cycle got stop=%b st=%0d want 0 0", stop, dbg_state);
        end
        checks++;
        if (acc_out !== 20'h0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL no_acc_when_disabled got acc=%h ovf=%b want 0 0", acc_out, ovf);
        end
    endtask

    task automatic test_signed_table();
        logic [7:0]  tb_b [8] = '{8'hF1, 8'h80, 8'h80, 8'hFF, 8'hF1, 8'h7F, 8'hFF, 8'h00};
        logic [7:0]  tb_q [8] = '{8'h0E, 8'h80, 8'h7F, 8'hFF, 8'h0E, 8'h7F, 8'hFF, 8'h5A};
        logic        tb_s [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] tb_p [8] = '{16'hFF2E, 16'h4000, 16'hC080, 16'hFE01,
                                  16'h0D2E, 16'h3F01, 16'h0001, 16'h0000};
        int lat, bc;
        for (int i = 0; i < 8; i++) begin
            run_op(tb_b[i], tb_q[i], tb_s[i], 1'b0, lat, bc);
            checks++;
            if (a_out !== tb_p[i] || lat !== 9) begin
                errors++;
                $display("FAIL product_%0d %h*%h s=%b got %h lat %0d want %h lat 9",
                         i, tb_b[i], tb_q[i], tb_s[i], a_out, lat, tb_p[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        b_in = 8'h0F; q_in = 8'h0E; signed_mode = 1'b0; acc_en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!stop && lat < 40) begin
            if (lat == 3) begin
                start = 1'b1; b_in = 8'hFF; q_in = 8'hFF; signed_mode = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++;
        if (a_out !== 16'h00D2 || lat !== 9) begin
            errors++;
            $display("FAIL start_mid_run got %h lat %0d want 00d2 lat 9", a_out, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, lat2;
        @(negedge clk);
        b_in = 8'h0F; q_in = 8'h0E; signed_mode = 1'b0; acc_en = 1'b0; start = 1'b1;
        @(negedge clk);
        b_in = 8'h80; q_in = 8'h7F; signed_mode = 1'b1;
        lat = 1;
        while (!stop && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (a_out !== 16'h00D2 || lat !== 9) begin
            errors++;
            $display("FAIL b2b_first got %h lat %0d want 00d2 lat 9", a_out, lat);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || a_out !== 16'h00D2) begin
            errors++;
            $display("FAIL b2b_chain_start got busy=%b a=%h want 1 00d2", busy, a_out);
        end
        lat2 = 1;
        while (!stop && lat2 < 40) begin
            @(negedge clk);
            lat2++;
        end
        checks++;
        if (a_out !== 16'hC080 || lat2 !== 9) begin
            errors++;
            $display("FAIL b2b_second got %h spacing %0d want c080 spacing 9", a_out, lat2);
        end
        @(negedge clk);
    endtask

    task automatic test_accumulate();
        int lat, bc;
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        checks++;
        if (acc_out !== 20'h0 || acc_out16 !== 16'h0) begin
            errors++;
            $display("FAIL acc_clear got %h/%h want 0/0", acc_out, acc_out16);
        end
        run_op(8'h7F, 8'h7F, 1'b1, 1'b1, lat, bc);
        run_op(8'h7F, 8'h7F, 1'b1, 1'b1, lat, bc);
        checks++;
        if (acc_out16 !== 16'h7E02 || ovf16 !== 1'b0) begin
            errors++;
            $display("FAIL acc16_two got %h ovf=%b want 7e02 0", acc_out16, ovf16);
        end
        run_op(8'h7F, 8'h7F, 1'b1, 1'b1, lat, bc);
        checks++;
        if (acc_out !== 20'h0BD03 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL acc_three got %h ovf=%b want 0bd03 0", acc_out, ovf);
        end
        checks++;
        if (acc_out16 !== 16'hBD03 || ovf16 !== 1'b1) begin
            errors++;
            $display("FAIL acc16_signed_ovf got %h ovf=%b want bd03 1", acc_out16, ovf16);
        end
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        checks++;
        if (ovf16 !== 1'b0 || acc_out16 !== 16'h0) begin
            errors++;
            $display("FAIL ovf_clear got acc=%h ovf=%b want 0 0", acc_out16, ovf16);
        end
        run_op(8'hFF, 8'hFF, 1'b0, 1'b1, lat, bc);
        run_op(8'hFF, 8'hFF, 1'b0, 1'b1, lat, bc);
        checks++;
        if (acc_out !== 20'h1FC02 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL acc_unsigned got %h ovf=%b want 1fc02 0", acc_out, ovf);
        end
        checks++;
        if (acc_out16 !== 16'hFC02 || ovf16 !== 1'b1) begin
            errors++;
            $display("FAIL acc16_carry got %h ovf=%b want fc02 1", acc_out16, ovf16);
        end
        run_op(8'h7F, 8'h7F, 1'b1, 1'b1, lat, bc);
        checks++;
        if (acc_out16 !== 16'h3B03 || ovf16 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %h ovf=%b want 3b03 1", acc_out16, ovf16);
        end
        checks++;
        if (acc_out !== 20'h23B03 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL acc_mixed got %h ovf=%b want 23b03 0", acc_out, ovf);
        end
    endtask

    task automatic test_acc_clr_result();
        int lat;
        @(negedge clk);
        b_in = 8'hF1; q_in = 8'h0E; signed_mode = 1'b1; acc_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!stop && lat < 40) begin
            acc_clr = (lat == 8);
            @(negedge clk);
            lat++;
        end
        acc_clr = 1'b0;
        checks++;
        if (acc_out !== 20'hFFF2E || lat !== 9) begin
            errors++;
            $display("FAIL clr_on_result got %h lat %0d want fff2e lat 9", acc_out, lat);
        end
        checks++;
        if (acc_out16 !== 16'hFF2E || ovf16 !== 1'b0) begin
            errors++;
            $display("FAIL clr_on_result16 got %h ovf=%b want ff2e 0", acc_out16, ovf16);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, stop_seen;
        @(negedge clk);
        b_in = 8'hFF; q_in = 8'hFF; signed_mode = 1'b0; acc_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, stop, ovf, a_out, acc_out, dbg_state} !== '0) begin
            errors++;
            $display("FAIL abort_outputs got busy=%b stop=%b ovf=%b a=%h acc=%h st=%0d want all 0",
                     busy, stop, ovf, a_out, acc_out, dbg_state);
        end
        @(negedge clk);
        reset = 1'b1;
        stop_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (stop) stop_seen++;
        end
        checks++;
        if (stop_seen !== 0) begin
            errors++;
            $display("FAIL abort_no_stop got %0d stop cycles want 0", stop_seen);
        end
        run_op(8'h80, 8'h7F, 1'b1, 1'b1, lat, bc);
        checks++;
        if (a_out !== 16'hC080 || acc_out !== 20'hFC080 || lat !== 9) begin
            errors++;
            $display("FAIL after_abort got a=%h acc=%h lat %0d want c080 fc080 lat 9",
                     a_out, acc_out, lat);
        end
        checks++;
        if (acc_out16 !== 16'hC080 || ovf16 !== 1'b0) begin
            errors++;
            $display("FAIL after_abort16 got %h ovf=%b want c080 0", acc_out16, ovf16);
        end
    endtask

    // Test sequence and final report
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_unsigned();
        test_signed_table();
        test_start_ignored();
        test_back_to_back();
        test_accumulate();
        test_acc_clr_result();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
